// File: rtl/data_stack.sv
// LIFO operand stack for the control FSM: push/pop/replace strobes, registered pop data,
// occupancy flags and sticky overflow/underflow error flags.
module data_stack #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rst_stack,
    input  logic                  push_stack,
    input  logic                  pop_stack,
    input  logic [DATA_WIDTH-1:0] stack_data_in,
    output logic [DATA_WIDTH-1:0] stack_data_out,
    output logic [DATA_WIDTH-1:0] tos,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic [ADDR_W-1:0]     w_top_idx;
    logic [ADDR_W-1:0]     w_wr_idx;
    logic                  w_we;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_top_idx = r_count[ADDR_W-1:0] - ADDR_W'(1);

    // A replace overwrites the top entry; a plain push (or push onto an empty stack)
    // appends. Writes are suppressed during any reset so a cleared stack stays clean.
    assign w_we     = rst & ~rst_stack & push_stack & (~w_full | pop_stack);
    assign w_wr_idx = (pop_stack & ~w_empty) ? w_top_idx : r_count[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_wr_idx] <= stack_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (rst_stack) begin
            r_count     <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case ({push_stack, pop_stack})
                2'b10: begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (w_empty) begin
                        r_data_out  <= '0;
                        r_underflow <= 1'b1;
                    end else begin
                        r_data_out <= r_mem[w_top_idx];
                        r_count    <= r_count - CNT_W'(1);
                    end
                end
                2'b11: begin
                    // Replace keeps depth; on an empty stack only the push half succeeds.
                    if (w_empty) begin
                        r_data_out  <= '0;
                        r_underflow <= 1'b1;
                        r_count     <= CNT_W'(1);
                    end else begin
                        r_data_out <= r_mem[w_top_idx];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stack_data_out = r_data_out;
    assign tos            = w_empty ? '0 : r_mem[w_top_idx];
    assign count          = r_count;
    assign empty          = w_empty;
    assign full           = w_full;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;

endmodule

// File: tb/tb_data_stack.sv
// Randomised and directed bench for data_stack; a queue-based stack model predicts each
// post-edge state and a negedge monitor compares it against the DUT.
module tb_data_stack;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rst_stack = 1'b0;
    logic          push_stack = 1'b0;
    logic          pop_stack = 1'b0;
    logic [DW-1:0] stack_data_in = '0;
    logic [DW-1:0] stack_data_out;
    logic [DW-1:0] tos;
    logic [CW-1:0] count;
    logic          empty, full, overflow, underflow;

    data_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rst_stack(rst_stack),
        .push_stack(push_stack), .pop_stack(pop_stack),
        .stack_data_in(stack_data_in), .stack_data_out(stack_data_out),
        .tos(tos), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int out;
        int cnt;
        int top;
        int emp;
        int ful;
        int ovf;
        int unf;
        int id;
    } snap_t;

    int    checks = 0;
    int    failures = 0;
    int    stk[$];
    int    m_out = 0;
    int    m_ovf = 0;
    int    m_unf = 0;
    int    txn = 0;
    snap_t exp_q[$];
    snap_t pending;
    bit    have_pending = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic snap_t snapshot();
        snap_t s;
        s.out = m_out;
        s.cnt = stk.size();
        s.top = (stk.size() == 0) ? 0 : stk[$];
        s.emp = (stk.size() == 0) ? 1 : 0;
        s.ful = (stk.size() == DEPTH) ? 1 : 0;
        s.ovf = m_ovf;
        s.unf = m_unf;
        s.id  = txn;
        return s;
    endfunction

    function automatic void model_reset();
        stk.delete();
        m_out = 0;
        m_ovf = 0;
        m_unf = 0;
    endfunction

    function automatic void model_step(input bit pu, input bit po, input bit rs, input int d);
        if (rs) begin
            model_reset();
        end else if (pu && po) begin
            if (stk.size() == 0) begin
                m_unf = 1;
                m_out = 0;
                stk.push_back(d);
            end else begin
                m_out = stk[$];
                stk[$] = d;
            end
        end else if (pu) begin
            if (stk.size() == DEPTH) m_ovf = 1;
            else stk.push_back(d);
        end else if (po) begin
            if (stk.size() == 0) begin
                m_unf = 1;
                m_out = 0;
            end else begin
                m_out = stk.pop_back();
            end
        end
    endfunction

    // One clock cycle: hand the previous cycle's prediction to the monitor, then drive
    // new strobes and predict the state they produce at the next edge.
    task automatic cycle(input bit pu, input bit po, input bit rs, input int d);
        @(posedge clk);
        if (have_pending) exp_q.push_back(pending);
        #1;
        push_stack    = pu;
        pop_stack     = po;
        rst_stack     = rs;
        stack_data_in = d[DW-1:0];
        txn++;
        model_step(pu, po, rs, d);
        pending      = snapshot();
        have_pending = 1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            snap_t e;
            e = exp_q.pop_front();
            $display("txn %0d: out=%h tos=%h count=%0d e=%0b f=%0b ovf=%0b unf=%0b",
                     e.id, stack_data_out, tos, count, empty, full, overflow, underflow);
            chk("stack_data_out", int'(stack_data_out), e.out);
            chk("count", int'(count), e.cnt);
            chk("tos", int'(tos), e.top);
            chk("empty", int'(empty), e.emp);
            chk("full", int'(full), e.ful);
            chk("overflow", int'(overflow), e.ovf);
            chk("underflow", int'(underflow), e.unf);
        end
    end

    initial begin
        int r;
        // Reset held for two cycles; outputs must already be at reset values.
        repeat (2) @(posedge clk);
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_out", int'(stack_data_out), 0);
        chk("rst_flags", int'({overflow, underflow}), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        pending      = snapshot();
        have_pending = 1;

        // Basic push / pop with held output.
        cycle(1, 0, 0, 'h0011);
        cycle(1, 0, 0, 'h0022);
        cycle(1, 0, 0, 'h0033);
        cycle(0, 1, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // Fill to full, overflow, drain.
        cycle(0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, i);
        cycle(1, 0, 0, 'hBEEF);
        cycle(1, 1, 0, 'h1234);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // Underflow then clear.
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 1, 0, 'h4444);
        cycle(0, 0, 1, 0);

        // Replace on a two-entry stack.
        cycle(1, 0, 0, 'h0005);
        cycle(1, 0, 0, 'h0007);
        cycle(1, 1, 0, 'h0009);
        cycle(0, 0, 0, 0);

        // rst_stack beats a concurrent push.
        cycle(1, 0, 0, 'h00AA);
        cycle(1, 0, 0, 'h00BB);
        cycle(1, 1, 1, 'h00CC);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);

        // Randomised traffic with alternating push/pop bias to reach both ends.
        for (int i = 0; i < 400; i++) begin
            bit pu, po, rs;
            r  = (i / 50) % 2;
            pu = ($urandom_range(99) < (r == 0 ? 75 : 30));
            po = ($urandom_range(99) < (r == 0 ? 25 : 70));
            rs = ($urandom_range(199) == 0);
            cycle(pu, po, rs, int'($urandom_range(16'hFFFF)));
        end
        cycle(0, 0, 0, 0);

        // Async reset arriving mid-push clears immediately.
        cycle(1, 0, 0, 'h0101);
        cycle(1, 0, 0, 'h0202);
        cycle(0, 0, 0, 0);
        @(posedge clk);
        exp_q.push_back(pending);
        have_pending = 0;
        @(negedge clk);
        #1;
        push_stack    = 1'b1;
        stack_data_in = 16'h0F0F;
        #2;
        rst = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_empty", int'(empty), 1);
        @(posedge clk);
        #1;
        push_stack = 1'b0;
        rst        = 1'b1;
        model_reset();
        pending      = snapshot();
        have_pending = 1;
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
